lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lcd_ctrl : character-LCD write sequencer (setup/enable/hold/wait) with a
//            one-entry pending slot.                              Rev 1.0
// ----------------------------------------------------------------------------
module lcd_ctrl #(
   parameter int unsigned T_SETUP = 2,
   parameter int unsigned T_EN    = 12,
   parameter int unsigned T_HOLD  = 2,
   parameter int unsigned T_EXEC  = 2000,
   parameter int unsigned T_CLEAR = 82000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wr_en,
   input  logic [31:0] i_wr_data,
   input  logic        i_lcd_on,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_overflow,
   output logic [31:0] o_status,
   output logic [7:0]  o_lcd_data,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic        o_lcd_en,
   output logic        o_lcd_on
);

   // A zero-length phase still occupies one cycle.
   localparam int unsigned C_SETUP = (T_SETUP == 0) ? 1 : T_SETUP;
   localparam int unsigned C_EN    = (T_EN    == 0) ? 1 : T_EN;
   localparam int unsigned C_HOLD  = (T_HOLD  == 0) ? 1 : T_HOLD;
   localparam int unsigned C_EXEC  = (T_EXEC  == 0) ? 1 : T_EXEC;
   localparam int unsigned C_CLEAR = (T_CLEAR == 0) ? 1 : T_CLEAR;

   localparam int unsigned C_MAX01 = (C_SETUP > C_EN)    ? C_SETUP : C_EN;
   localparam int unsigned C_MAX23 = (C_HOLD  > C_EXEC)  ? C_HOLD  : C_EXEC;
   localparam int unsigned C_MAX03 = (C_MAX01 > C_MAX23) ? C_MAX01 : C_MAX23;
   localparam int unsigned C_MAX   = (C_MAX03 > C_CLEAR) ? C_MAX03 : C_CLEAR;
   localparam int unsigned CW      = (C_MAX > 2) ? $clog2(C_MAX) : 2;

   localparam logic [CW-1:0] C_LD_SETUP = CW'(C_SETUP - 1);
   localparam logic [CW-1:0] C_LD_EN    = CW'(C_EN    - 1);
   localparam logic [CW-1:0] C_LD_HOLD  = CW'(C_HOLD  - 1);
   localparam logic [CW-1:0] C_LD_EXEC  = CW'(C_EXEC  - 1);
   localparam logic [CW-1:0] C_LD_CLEAR = CW'(C_CLEAR - 1);
   localparam logic [CW-1:0] C_ONE      = CW'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_PULSE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_WAIT  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          act_rs_q, act_rs_d;
   logic [7:0]    act_byte_q, act_byte_d;
   logic          buf_vld_q, buf_vld_d;
   logic          buf_rs_q, buf_rs_d;
   logic [7:0]    buf_byte_q, buf_byte_d;
   logic          ovf_q, ovf_d;
   logic          done_q, done_d;
   logic          lcd_on_q;

   logic          w_rs;
   logic [7:0]    w_byte;
   logic          w_cnt_zero;
   logic          w_long;
   logic [CW-1:0] w_ld_wait;
   logic          w_take;
   logic          w_unused;

   assign w_rs       = i_wr_data[9];
   assign w_byte     = i_wr_data[7:0];
   assign w_unused   = ^{i_wr_data[31:10], i_wr_data[8]};
   assign w_cnt_zero = (cnt_q == '0);

   // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
   assign w_long    = !act_rs_q && ((act_byte_q == 8'h01) || (act_byte_q[7:1] == 7'b0000001));
   assign w_ld_wait = w_long ? C_LD_CLEAR : C_LD_EXEC;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         act_rs_q   <= 1'b0;
         act_byte_q <= 8'h00;
         buf_vld_q  <= 1'b0;
         buf_rs_q   <= 1'b0;
         buf_byte_q <= 8'h00;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         lcd_on_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         act_rs_q   <= act_rs_d;
         act_byte_q <= act_byte_d;
         buf_vld_q  <= buf_vld_d;
         buf_rs_q   <= buf_rs_d;
         buf_byte_q <= buf_byte_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
         lcd_on_q   <= i_lcd_on;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      act_rs_d   = act_rs_q;
      act_byte_d = act_byte_q;
      buf_vld_d  = buf_vld_q;
      buf_rs_d   = buf_rs_q;
      buf_byte_d = buf_byte_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      w_take     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_wr_en) begin
               w_take     = 1'b1;
               act_rs_d   = w_rs;
               act_byte_d = w_byte;
               state_d    = ST_SETUP;
               cnt_d      = C_LD_SETUP;
            end
         end
         ST_SETUP: begin
            if (w_cnt_zero) begin
               state_d = ST_PULSE;
               cnt_d   = C_LD_EN;
            end else begin
               cnt_d = cnt_q - C_ONE;
            end
         end
         ST_PULSE: begin
            if (w_cnt_zero) begin
               state_d = ST_HOLD;
               cnt_d   = C_LD_HOLD;
            end else begin
               cnt_d = cnt_q - C_ONE;
            end
         end
         ST_HOLD: begin
            if (w_cnt_zero) begin
               state_d = ST_WAIT;
               cnt_d   = w_ld_wait;
            end else begin
               cnt_d = cnt_q - C_ONE;
            end
         end
         ST_WAIT: begin
            if (w_cnt_zero) begin
               done_d = 1'b1;
               if (buf_vld_q) begin
                  act_rs_d   = buf_rs_q;
                  act_byte_d = buf_byte_q;
                  buf_vld_d  = 1'b0;
                  state_d    = ST_SETUP;
                  cnt_d      = C_LD_SETUP;
               end else if (i_wr_en) begin
                  // Slot is empty: start the new word directly, no idle gap.
                  w_take     = 1'b1;
                  act_rs_d   = w_rs;
                  act_byte_d = w_byte;
                  state_d    = ST_SETUP;
                  cnt_d      = C_LD_SETUP;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - C_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Uses buf_vld_d so a slot freed this cycle can be refilled at once.
      if (i_wr_en && !w_take) begin
         if (!buf_vld_d) begin
            buf_vld_d  = 1'b1;
            buf_rs_d   = w_rs;
            buf_byte_d = w_byte;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   assign o_busy     = (state_q != ST_IDLE) || buf_vld_q;
   assign o_done     = done_q;
   assign o_overflow = ovf_q;
   assign o_lcd_data = act_byte_q;
   assign o_lcd_rs   = act_rs_q;
   assign o_lcd_rw   = 1'b0;
   assign o_lcd_en   = (state_q == ST_PULSE);
   assign o_lcd_on   = lcd_on_q;
   // Last RS sits at bit 9 to mirror the write-word layout.
   assign o_status   = {o_busy, ovf_q, 20'b0, act_rs_q, 1'b0, act_byte_q};

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lcd_ctrl : directed and random checks of lcd_ctrl against a schedule model.
//                                                                   Rev 1.0
// ----------------------------------------------------------------------------
module tb_lcd_ctrl;

   localparam int S  = 2;
   localparam int E  = 4;
   localparam int H  = 2;
   localparam int WX = 10;
   localparam int WC = 30;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        lcd_on;
   logic        busy, done, overflow, lcd_rs, lcd_rw, lcd_en, lcd_on_o;
   logic [31:0] status;
   logic [7:0]  lcd_data;

   always #5 clk = ~clk;

   lcd_ctrl #(
      .T_SETUP(S), .T_EN(E), .T_HOLD(H), .T_EXEC(WX), .T_CLEAR(WC)
   ) u_dut (
      .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
      .i_lcd_on(lcd_on), .o_busy(busy), .o_done(done), .o_overflow(overflow),
      .o_status(status), .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs),
      .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en), .o_lcd_on(lcd_on_o)
   );

   // Each accepted transfer: SETUP starts at s, o_done pulses at e.
   typedef struct packed {
      int         s;
      int         e;
      logic       rs;
      logic [7:0] b;
   } xfer_t;

   xfer_t xq[$];
   int    dq[$];
   int    cyc, t0;
   int    errors, checks;
   logic  m_ovf, m_on;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int xfer_len(input logic rs, input logic [7:0] b);
      logic [6:0] hi;
      bit         lng;
      hi  = b[7:1];
      lng = !rs && ((b == 8'h01) || (hi == 7'd1));
      return S + E + H + (lng ? WC : WX);
   endfunction

   function automatic int dq_get(input int i);
      return (dq.size() > i) ? dq[i] : -1;
   endfunction

   task automatic step(input logic w, input logic [31:0] d, input logic r, input logic on);
      int         n, st;
      logic       e_busy, e_en, e_done, e_rs;
      logic [7:0] e_b;
      xfer_t      x;
      rst = r; wr_en = w; wr_data = d; lcd_on = on;
      @(negedge clk);
      e_busy = 1'b0; e_en = 1'b0; e_done = 1'b0; e_rs = 1'b0; e_b = 8'h00;
      foreach (xq[i]) begin
         if (xq[i].e > cyc) e_busy = 1'b1;
         if ((xq[i].s + S <= cyc) && (cyc < xq[i].s + S + E)) e_en = 1'b1;
         if (xq[i].e == cyc) e_done = 1'b1;
         if (xq[i].s <= cyc) begin
            e_rs = xq[i].rs;
            e_b  = xq[i].b;
         end
      end
      chk("busy",     32'(busy),     32'(e_busy));
      chk("done",     32'(done),     32'(e_done));
      chk("en",       32'(lcd_en),   32'(e_en));
      chk("rs",       32'(lcd_rs),   32'(e_rs));
      chk("data",     32'(lcd_data), 32'(e_b));
      chk("rw",       32'(lcd_rw),   32'd0);
      chk("lcd_on",   32'(lcd_on_o), 32'(m_on));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("status",   status, {e_busy, m_ovf, 20'b0, e_rs, 1'b0, e_b});
      if (done === 1'b1) dq.push_back(cyc - t0);
      if (r) begin
         xq.delete();
         m_ovf = 1'b0;
         m_on  = 1'b0;
      end else begin
         m_on = on;
         if (w) begin
            n  = 0;
            st = cyc + 1;
            foreach (xq[i]) begin
               if (xq[i].e > cyc + 1) n++;
               if (xq[i].e > st) st = xq[i].e;
            end
            if (n < 2) begin
               x.s  = st;
               x.e  = st + xfer_len(d[9], d[7:0]);
               x.rs = d[9];
               x.b  = d[7:0];
               xq.push_back(x);
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Reset, then n cycles with writes of (d + t) at relative cycles w0/w1/w2.
   task automatic seq(input int n, input int w0, input int w1, input int w2, input logic [31:0] d);
      step(1'b0, 32'd0, 1'b1, 1'b1);
      t0 = cyc;
      dq.delete();
      for (int t = 0; t < n; t++)
         step((t == w0) || (t == w1) || (t == w2), d + 32'(t), 1'b0, 1'b1);
   endtask

   initial begin
      errors = 0; checks = 0; cyc = 0; t0 = 0;
      m_ovf = 1'b0; m_on = 1'b0;
      rst = 1'b1; wr_en = 1'b0; wr_data = 32'd0; lcd_on = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;

      seq(25, 0, -1, -1, 32'h0000_0241);
      chk("t1_ndone", 32'(dq.size()), 32'd1);
      chk("t1_done", 32'(dq_get(0)), 32'd19);

      seq(45, 0, -1, -1, 32'h0000_0001);
      chk("clr_done", 32'(dq_get(0)), 32'd39);
      seq(45, 0, -1, -1, 32'h0000_0002);
      chk("home_done", 32'(dq_get(0)), 32'd39);
      seq(25, 0, -1, -1, 32'h0000_0038);
      chk("cmd_done", 32'(dq_get(0)), 32'd19);
      seq(25, 0, -1, -1, 32'h0000_0201);
      chk("data01_done", 32'(dq_get(0)), 32'd19);

      seq(45, 0, 5, -1, 32'h0000_0241);
      chk("b2b_ndone", 32'(dq.size()), 32'd2);
      chk("b2b_done0", 32'(dq_get(0)), 32'd19);
      chk("b2b_done1", 32'(dq_get(1)), 32'd37);
      chk("b2b_ovf", 32'(overflow), 32'd0);

      seq(60, 0, 3, 4, 32'h0000_0250);
      chk("ovf_ndone", 32'(dq.size()), 32'd2);
      chk("ovf_done1", 32'(dq_get(1)), 32'd37);
      chk("ovf_sticky", 32'(overflow), 32'd1);

      seq(65, 0, 3, 18, 32'h0000_0260);
      chk("refill_ndone", 32'(dq.size()), 32'd3);
      chk("refill_done2", 32'(dq_get(2)), 32'd55);
      chk("refill_ovf", 32'(overflow), 32'd0);

      step(1'b0, 32'd0, 1'b1, 1'b1);
      t0 = cyc;
      dq.delete();
      step(1'b1, 32'h0000_0241, 1'b0, 1'b1);
      for (int t = 1; t < 4; t++) step(1'b0, 32'd0, 1'b0, 1'b1);
      step(1'b1, 32'h0000_0299, 1'b1, 1'b1);
      chk("rst_en", 32'(lcd_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_data", 32'(lcd_data), 32'd0);
      for (int t = 0; t < 30; t++) step(1'b0, 32'd0, 1'b0, 1'b1);
      chk("rst_nodone", 32'(dq.size()), 32'd0);
      t0 = cyc;
      step(1'b1, 32'h0000_0242, 1'b0, 1'b1);
      for (int t = 1; t < 25; t++) step(1'b0, 32'd0, 1'b0, 1'b1);
      chk("rst_after_done", 32'(dq_get(0)), 32'd19);

      step(1'b0, 32'd0, 1'b1, 1'b0);
      for (int k = 0; k < 1500; k++) begin
         logic        w, r;
         logic [31:0] d;
         w = ($urandom_range(0, 9) == 0);
         d = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            d[9]   = 1'b0;
            d[7:0] = 8'($urandom_range(0, 3));
         end
         r = ($urandom_range(0, 299) == 0);
         step(w, d, r, 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
